// File: rtl/prefix_addsub_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with a global-stall valid/ready pipeline.
// A register bank follows every REG_EVERY prefix levels and always the last level.
module prefix_addsub_pipe #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned TAG_W     = 20,
  parameter int unsigned REG_EVERY = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [TAG_W-1:0] tag_out
);

  localparam int unsigned L = $clog2(WIDTH);
  // Sideband word carried beside G/P: {valid, tag, c0, original p}.
  localparam int unsigned SBW = WIDTH + TAG_W + 2;

  logic             advance;
  logic [WIDTH-1:0] b_x, g_bit, p_pre, g_pre;
  logic             c0;
  logic [SBW-1:0]   sb_pre;

  assign b_x    = sub ? ~b : b;
  assign c0     = sub ^ cin;
  assign g_bit  = a & b_x;
  assign p_pre  = a ^ b_x;
  // Carry-in folded into bit 0 so the prefix tree yields true carries directly.
  assign g_pre  = {g_bit[WIDTH-1:1], g_bit[0] | (p_pre[0] & c0)};
  assign sb_pre = {in_valid, tag_in, c0, p_pre};

  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int unsigned D      = 1 << (k - 1);
    localparam bit          RegHere = ((k % REG_EVERY) == 0) || (k == L);

    logic [WIDTH-1:0] g_i, p_i, g_c, g_s;
    logic [SBW-1:0]   sb_i, sb_s;

    if (k == 1) begin : g_src0
      assign g_i  = g_pre;
      assign p_i  = p_pre;
      assign sb_i = sb_pre;
    end else begin : g_srcn
      assign g_i  = g_lvl[k-1].g_s;
      assign p_i  = g_lvl[k-1].g_p.p_s;
      assign sb_i = g_lvl[k-1].sb_s;
    end

    assign g_c = {g_i[WIDTH-1:D] | (p_i[WIDTH-1:D] & g_i[WIDTH-1-D:0]), g_i[D-1:0]};

    if (RegHere) begin : g_reg
      logic [WIDTH-1:0] g_q;
      logic [SBW-1:0]   sb_q;
      always_ff @(posedge clk) begin
        if (clear) begin
          g_q  <= '0;
          sb_q <= '0;
        end else if (advance) begin
          g_q  <= g_c;
          sb_q <= sb_i;
        end
      end
      assign g_s  = g_q;
      assign sb_s = sb_q;
    end else begin : g_wire
      assign g_s  = g_c;
      assign sb_s = sb_i;
    end

    // Group propagate is dead after the final level; only carries are needed.
    if (k < L) begin : g_p
      logic [WIDTH-1:0] p_c, p_s;
      assign p_c = {p_i[WIDTH-1:D] & p_i[WIDTH-1-D:0], p_i[D-1:0]};
      if (RegHere) begin : g_preg
        logic [WIDTH-1:0] p_q;
        always_ff @(posedge clk) begin
          if (clear) begin
            p_q <= '0;
          end else if (advance) begin
            p_q <= p_c;
          end
        end
        assign p_s = p_q;
      end else begin : g_pwire
        assign p_s = p_c;
      end
    end else begin : g_pend
      logic unused_p;
      assign unused_p = ^p_i[D-1:0];
    end
  end

  logic [WIDTH-1:0] g_f, p_f;
  logic [SBW-1:0]   sb_f;
  logic             c0_f;

  assign g_f  = g_lvl[L].g_s;
  assign sb_f = g_lvl[L].sb_s;
  assign p_f  = sb_f[WIDTH-1:0];
  assign c0_f = sb_f[WIDTH];

  assign out_valid = sb_f[SBW-1];
  assign tag_out   = sb_f[WIDTH+1 +: TAG_W];
  assign sum       = p_f ^ {g_f[WIDTH-2:0], c0_f};
  assign cout      = g_f[WIDTH-1];
  assign ovf       = g_f[WIDTH-1] ^ g_f[WIDTH-2];

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

endmodule

// File: tb/tb_prefix_addsub_pipe.sv
// Bench for prefix_addsub_pipe: three parameter variants, directed vectors,
// streaming with stalls and a mid-flight reset, checked against an integer model.
module tb_prefix_addsub_pipe;

  localparam int NDUT = 3;
  int wid [NDUT] = '{64, 24, 2};
  int lat [NDUT] = '{6, 3, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clear0, iv0, ir0, cin0, sub0, ov0, ordy0, co0, of0;
  logic [63:0] a0, b0, sum0;
  logic [19:0] tag0, to0;
  logic        clear1, iv1, ir1, cin1, sub1, ov1, ordy1, co1, of1;
  logic [23:0] a1, b1, sum1;
  logic [19:0] tag1, to1;
  logic        clear2, iv2, ir2, cin2, sub2, ov2, ordy2, co2, of2;
  logic [1:0]  a2, b2, sum2;
  logic [19:0] tag2, to2;

  prefix_addsub_pipe #(.WIDTH(64), .TAG_W(20), .REG_EVERY(1)) u_dut0 (
    .clk(clk), .clear(clear0), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .cin(cin0),
    .sub(sub0), .tag_in(tag0), .out_valid(ov0), .out_ready(ordy0), .sum(sum0), .cout(co0),
    .ovf(of0), .tag_out(to0)
  );
  prefix_addsub_pipe #(.WIDTH(24), .TAG_W(20), .REG_EVERY(2)) u_dut1 (
    .clk(clk), .clear(clear1), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
    .sub(sub1), .tag_in(tag1), .out_valid(ov1), .out_ready(ordy1), .sum(sum1), .cout(co1),
    .ovf(of1), .tag_out(to1)
  );
  prefix_addsub_pipe #(.WIDTH(2), .TAG_W(20), .REG_EVERY(1)) u_dut2 (
    .clk(clk), .clear(clear2), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .cin(cin2),
    .sub(sub2), .tag_in(tag2), .out_valid(ov2), .out_ready(ordy2), .sum(sum2), .cout(co2),
    .ovf(of2), .tag_out(to2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [63:0] a, input logic [63:0] b,
                       input logic cin, input logic sub, input logic [19:0] tag);
    case (d)
      0: begin iv0 = v; a0 = a;        b0 = b;        cin0 = cin; sub0 = sub; tag0 = tag; end
      1: begin iv1 = v; a1 = a[23:0];  b1 = b[23:0];  cin1 = cin; sub1 = sub; tag1 = tag; end
      default: begin
        iv2 = v; a2 = a[1:0]; b2 = b[1:0]; cin2 = cin; sub2 = sub; tag2 = tag;
      end
    endcase
  endtask

  task automatic set_ready(input int d, input logic r);
    case (d)
      0:       ordy0 = r;
      1:       ordy1 = r;
      default: ordy2 = r;
    endcase
  endtask

  task automatic set_clear(input int d, input logic c);
    case (d)
      0:       clear0 = c;
      1:       clear1 = c;
      default: clear2 = c;
    endcase
  endtask

  typedef struct {
    logic        ov, ir, co, of;
    logic [63:0] s;
    logic [19:0] t;
  } obs_t;

  function automatic obs_t observe(input int d);
    obs_t o;
    case (d)
      0: begin o.ov = ov0; o.ir = ir0; o.co = co0; o.of = of0; o.s = sum0; o.t = to0; end
      1: begin
        o.ov = ov1; o.ir = ir1; o.co = co1; o.of = of1; o.s = {40'b0, sum1}; o.t = to1;
      end
      default: begin
        o.ov = ov2; o.ir = ir2; o.co = co2; o.of = of2; o.s = {62'b0, sum2}; o.t = to2;
      end
    endcase
    return o;
  endfunction

  typedef struct {
    logic [63:0] sum;
    logic        cout, ovf;
  } res_t;

  function automatic logic [63:0] width_mask(input int w);
    return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  // Exact integer arithmetic: unsigned for sum/carry, signed range test for overflow.
  function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub);
    res_t               r;
    logic [65:0]        ua, ub, ur, uc;
    logic signed [65:0] sa, sb, sr, lim, sc;
    ua  = {2'b0, a & width_mask(w)};
    ub  = {2'b0, b & width_mask(w)};
    uc  = {65'b0, cin};
    ur  = sub ? (ua - ub - uc) : (ua + ub + uc);
    r.sum  = ur[63:0] & width_mask(w);
    r.cout = sub ? (ua >= ub + uc) : ur[w];
    lim = 66'sd1 <<< (w - 1);
    sa  = $signed(ua);
    sb  = $signed(ub);
    sc  = $signed(uc);
    if (ua[w-1]) sa = sa - (lim <<< 1);
    if (ub[w-1]) sb = sb - (lim <<< 1);
    sr  = sub ? (sa - sb - sc) : (sa + sb + sc);
    r.ovf = (sr >= lim) || (sr < -lim);
    return r;
  endfunction

  typedef struct {
    int          d;
    logic [63:0] a, b;
    logic        cin, sub;
    logic [19:0] tag;
    logic [63:0] sum;
    logic        cout, ovf;
  } vec_t;

  vec_t vt [11];

  task automatic run_single(input vec_t v);
    obs_t o;
    int   early;
    string nm;
    nm = $sformatf("d%0d tag%0h", v.d, v.tag);
    set_ready(v.d, 1'b1);
    @(posedge clk); #1;
    drive(v.d, 1'b1, v.a, v.b, v.cin, v.sub, v.tag);
    @(negedge clk);
    o = observe(v.d);
    chk({nm, " in_ready"}, o.ir, 1);
    @(posedge clk); #1;
    drive(v.d, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    early = 0;
    for (int e = 1; e <= lat[v.d]; e++) begin
      if (e > 1) @(posedge clk);
      @(negedge clk);
      o = observe(v.d);
      if (e < lat[v.d] && o.ov) early++;
    end
    chk({nm, " early_valid"}, early, 0);
    chk({nm, " out_valid"}, o.ov, 1);
    chk({nm, " sum"}, o.s, v.sum);
    chk({nm, " cout"}, o.co, v.cout);
    chk({nm, " ovf"}, o.of, v.ovf);
    chk({nm, " tag"}, o.t, v.tag);
    @(posedge clk);
  endtask

  // Streams n operations; a stall window or random ready/valid; scoreboard ordered by acceptance.
  task automatic stream(input int d, input int n, input int tbase, input int st_start,
                        input int st_len, input bit rnd, input bit chk_tput);
    res_t        q_r [$];
    logic [19:0] q_t [$];
    int          q_c [$];
    logic [63:0] ca, cb;
    logic        ccin, csub, rdy;
    logic [19:0] ctag;
    bit          pend;
    int          idx, got, first, last, cyc;
    obs_t        o;
    string       nm;
    nm = $sformatf("stream d%0d base%0d", d, tbase);
    idx = 0; got = 0; pend = 0; first = -1; last = -1;
    ca = '0; cb = '0; ccin = 1'b0; csub = 1'b0; ctag = '0;
    for (cyc = 0; cyc < n * 6 + 100 && !(idx == n && q_r.size() == 0); cyc++) begin
      @(posedge clk); #1;
      if (!pend && idx < n && (!rnd || $urandom_range(0, 3) != 0)) begin
        ca   = {$urandom, $urandom} & width_mask(wid[d]);
        cb   = {$urandom, $urandom} & width_mask(wid[d]);
        ccin = 1'($urandom_range(0, 1));
        csub = 1'($urandom_range(0, 1));
        ctag = 20'(tbase + idx);
        pend = 1;
      end
      drive(d, pend, ca, cb, ccin, csub, ctag);
      rdy = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= st_start && cyc < st_start + st_len);
      set_ready(d, rdy);
      @(negedge clk);
      o = observe(d);
      chk({nm, " in_ready"}, o.ir, !o.ov | rdy);
      if (o.ov) begin
        if (q_r.size() == 0) begin
          chk({nm, " spurious_valid"}, o.ov, 0);
        end else begin
          chk({nm, " sum"}, o.s, q_r[0].sum);
          chk({nm, " cout"}, o.co, q_r[0].cout);
          chk({nm, " ovf"}, o.of, q_r[0].ovf);
          chk({nm, " tag"}, o.t, q_t[0]);
          if (rdy) begin
            if (chk_tput) chk({nm, " latency"}, cyc - q_c[0], lat[d]);
            void'(q_r.pop_front());
            void'(q_t.pop_front());
            void'(q_c.pop_front());
            got++;
            if (first < 0) first = cyc;
            last = cyc;
          end
        end
      end
      if (pend && o.ir) begin
        q_r.push_back(model(wid[d], ca, cb, ccin, csub));
        q_t.push_back(ctag);
        q_c.push_back(cyc);
        idx++;
        pend = 0;
      end
    end
    @(posedge clk); #1;
    drive(d, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    set_ready(d, 1'b1);
    chk({nm, " results"}, got, n);
    chk({nm, " leftover"}, q_r.size(), 0);
    if (chk_tput) chk({nm, " span"}, last - first, n - 1);
  endtask

  task automatic reset_mid_op();
    obs_t o;
    int   seen;
    set_ready(0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0, 20'(20'hBAD0 + i));
      @(negedge clk);
      o = observe(0);
      chk("rst accept in_ready", o.ir, 1);
    end
    @(posedge clk); #1;
    drive(0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    set_clear(0, 1'b1);
    @(posedge clk); #1;
    set_clear(0, 1'b0);
    @(negedge clk);
    o = observe(0);
    chk("rst out_valid", o.ov, 0);
    chk("rst sum", o.s, 0);
    seen = 0;
    for (int i = 0; i < lat[0] + 4; i++) begin
      @(negedge clk);
      o = observe(0);
      if (o.ov) seen++;
    end
    chk("rst discarded", seen, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    for (int d = 0; d < NDUT; d++) begin
      drive(d, 1'b0, '0, '0, 1'b0, 1'b0, '0);
      set_ready(d, 1'b1);
      set_clear(d, 1'b1);
    end

    vt[0]  = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 20'h5, 64'h0, 1'b1, 1'b0};
    vt[1]  = '{0, 64'h0, 64'h1, 1'b0, 1'b1, 20'h6, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vt[2]  = '{0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 20'h7,
               64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vt[3]  = '{0, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 20'h8,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vt[4]  = '{0, 64'h5, 64'h3, 1'b1, 1'b1, 20'h9, 64'h1, 1'b1, 1'b0};
    vt[5]  = '{1, 64'hFF_FFFF, 64'h1, 1'b0, 1'b0, 20'hA, 64'h0, 1'b1, 1'b0};
    vt[6]  = '{1, 64'h80_0000, 64'h80_0000, 1'b0, 1'b0, 20'hB, 64'h0, 1'b1, 1'b1};
    vt[7]  = '{2, 64'h1, 64'h1, 1'b0, 1'b0, 20'hC, 64'h2, 1'b0, 1'b1};
    vt[8]  = '{2, 64'h3, 64'h1, 1'b0, 1'b0, 20'hD, 64'h0, 1'b1, 1'b0};
    vt[9]  = '{2, 64'h2, 64'h1, 1'b0, 1'b1, 20'hE, 64'h1, 1'b1, 1'b1};
    vt[10] = '{2, 64'h0, 64'h0, 1'b1, 1'b1, 20'hF, 64'h3, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      o = observe(d);
      chk($sformatf("reset d%0d out_valid", d), o.ov, 0);
      chk($sformatf("reset d%0d sum", d), o.s, 0);
      chk($sformatf("reset d%0d cout", d), o.co, 0);
      chk($sformatf("reset d%0d ovf", d), o.of, 0);
      chk($sformatf("reset d%0d tag", d), o.t, 0);
      chk($sformatf("reset d%0d in_ready", d), o.ir, 1);
    end
    @(posedge clk); #1;
    for (int d = 0; d < NDUT; d++) set_clear(d, 1'b0);

    for (int i = 0; i < 11; i++) run_single(vt[i]);

    stream(0, 10, 0, -1, 0, 1'b0, 1'b1);
    stream(0, 10, 16, 8, 3, 1'b0, 1'b0);
    reset_mid_op();
    stream(0, 200, 100, -1, 0, 1'b1, 1'b0);
    stream(1, 1000, 1000, -1, 0, 1'b1, 1'b0);
    stream(2, 100, 4000, -1, 0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prefix_addsub_pipe.md
# prefix_addsub_pipe

Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor with valid/ready flow control and a tag sideband. It is the general-width successor of the fixed 64-bit pipelined carry-lookahead adder. It adds carry-in, subtract mode, signed-overflow detection and back-pressure. It sits in the datapath of the pipelined floating-point units: mantissa/exponent add, and integer add in the FP multiplier.

## Interface
- WIDTH, 64: operand width; legal range 2..128.
- TAG_W, 20: sideband tag width, carried alongside each operation; legal minimum 1.
- REG_EVERY, 1: number of prefix levels between pipeline registers; legal range 1..L.
- Derived L = ceil(log2(WIDTH)); LAT = ceil(L / REG_EVERY). For the defaults, L = 6 and LAT = 6.
- clk  in  1  rising-edge clock; the only clock.
- clear  in  1  synchronous, active-high reset.
- in_valid  in  1  input operation present.
- in_ready  out  1  block accepts the input this cycle.
- a, b  in  WIDTH  operands.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0: a+b+cin; 1: a-b-cin.
- tag_in  in  TAG_W  sideband tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1. For sub, 1 = no borrow.
- ovf  out  1  two's-complement overflow.
- tag_out  out  TAG_W  tag of the presented result.

## Operation
- Pre-stage, combinational:
  - b' = sub ? ~b : b.
  - c0 = sub ? ~cin : cin.
  - g[i] = a[i] & b'[i]; p[i] = a[i] ^ b'[i].
  - Bit 0 generate is folded with the carry-in: G[0] = g[0] | (p[0] & c0).
- Prefix level k (1..L), distance d = 2^(k-1):
  - For i >= d: G = G[i] | (P[i] & G[i-d]) and P = P[i] & P[i-d].
  - For i < d: G and P pass through unchanged.
- Pipeline registers follow levels REG_EVERY, 2·REG_EVERY, … and always follow level L, giving LAT register stages in total.
- Each stage registers all of the following:
  - the current G/P vectors;
  - the original p vector, c0, and the operand MSBs;
  - the tag;
  - a valid bit.
- Post-stage, combinational from the last register:
  - carry[i] = G[i] (the carry out of bit i);
  - sum[0] = p[0] ^ c0;
  - sum[i] = p[i] ^ carry[i-1];
  - cout = carry[WIDTH-1];
  - ovf = carry[WIDTH-1] ^ carry[WIDTH-2].
- Flow control is a global-stall pipeline:
  - advance = ~out_valid | out_ready.
  - in_ready = advance.
  - On advance, every stage loads from its predecessor; stage 0 loads v = in_valid.
  - When not advancing, all stages hold. This includes the data registers and the tag.
  - Data registers load on advance regardless of the valid bit. Results are meaningful only while out_valid = 1.
- A transfer happens when in_valid & in_ready (input side) or out_valid & out_ready (output side).

## Timing
- Reset: clear = 1 at a rising edge zeroes all valid bits and all data registers. Next cycle the outputs are:
  - out_valid = 0;
  - sum = 0, cout = 0, ovf = 0;
  - tag_out = 0;
  - in_ready = 1.
- Reset mid-operation discards every in-flight operation; nothing is replayed. clear has priority over advance.
- Latency: an operation accepted at edge N appears with out_valid = 1 after edge N+LAT−1. It is visible in the cycle following that edge, provided no stall occurred.
- Throughput: one operation per cycle while out_ready = 1. No bubbles are inserted.
- Stall: while out_valid = 1 and out_ready = 0:
  - in_ready = 0;
  - sum, cout, ovf and tag_out are held stable;
  - the input is not sampled.
- Bubbles do not collapse under stall; internal invalid stages hold too.
- in_ready depends combinationally on out_ready; no other comb path runs from input to output.
- Operations complete in acceptance order. tag_out always pairs with its own sum.

## Test plan
- Carry ripple, WIDTH=64, REG_EVERY=1: a = 0xFFFF_FFFF_FFFF_FFFF, b = 0, cin = 1, sub = 0, tag = 0x5 -> after 6 cycles: sum = 0, cout = 1, ovf = 0, tag_out = 0x5.
- Subtract and overflow:
  - a = 0, b = 1, cin = 0, sub = 1 -> sum = 0xFFFF_FFFF_FFFF_FFFF, cout = 0, ovf = 0.
  - a = 0x7FFF_FFFF_FFFF_FFFF, b = 1, add -> sum = 0x8000_0000_0000_0000, ovf = 1, cout = 0.
- Back-to-back and stall:
  - 10 consecutive random operations with tags 0..9 and out_ready = 1 -> 10 results on 10 consecutive cycles, in order, matching the reference model.
  - Then out_ready = 0 for 3 cycles mid-stream -> in_ready = 0 and outputs frozen for those cycles; no loss or duplication.
- Reset mid-operation: accept 4 operations, assert clear for 1 cycle -> next cycle out_valid = 0 and sum = 0. None of the 4 results ever appears.
- Parameter variant, WIDTH=24, REG_EVERY=2: L = 5, LAT = 3. a = 0xFFFFFF, b = 0x000001 -> sum = 0, cout = 1 three cycles after acceptance. Then 1000 random add/sub operations with random out_ready must match the reference model.
- Minimum width, WIDTH=2, REG_EVERY=1: LAT = 1. a = 2'b01, b = 2'b01, add -> sum = 2'b10, ovf = 1, cout = 0.
